// File: rtl/uart_rx_core.sv
// Oversampling 8N1 UART receiver: 16 ticks per bit, 3-sample majority vote per bit,
// registered byte/strobe outputs. The stop bit is decided early so back-to-back frames resync.
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          baud_divisor,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 frame_err,
  output logic                 rx_busy,
  output logic                 rx_tickk
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  logic [15:0] div_q, div_d, div_lim;
  logic        tick, tick_q;

  logic [3:0]           tcnt_q, tcnt_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [2:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 ferr_q, ferr_d;

  logic vote_mid, vote_stop;
  logic cnt_run, tcnt_clr, samp_en, shift_en, bcnt_clr, done_ok, done_err;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  // Free-running tick divider; >= lets a reduced divisor take effect without waiting a full wrap.
  assign div_lim = (baud_divisor > 16'd1) ? (baud_divisor - 16'd1) : 16'd0;
  assign tick    = (div_q >= div_lim);
  assign div_d   = tick ? 16'd0 : (div_q + 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick;
    end
  end

  assign vote_mid  = maj3(samp_q[0], samp_q[1], samp_q[2]);
  // In STOP the third sample is the live value on the deciding tick.
  assign vote_stop = maj3(samp_q[0], samp_q[1], rxs);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick && !rxs) state_d = S_START;
      S_START: if (tick && tcnt_q == 4'd15) state_d = vote_mid ? S_IDLE : S_DATA;
      S_DATA:  if (tick && tcnt_q == 4'd15 && bcnt_q == 4'(DATA_BITS-1)) state_d = S_STOP;
      S_STOP:  if (tick && tcnt_q == 4'd9) state_d = vote_stop ? S_IDLE : S_BRK;
      S_BRK:   if (rxs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_busy  = 1'b1;
    cnt_run  = 1'b0;
    tcnt_clr = 1'b0;
    shift_en = 1'b0;
    bcnt_clr = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        rx_busy  = 1'b0;
        tcnt_clr = tick && !rxs;
      end
      S_START: begin
        cnt_run  = tick;
        bcnt_clr = tick && tcnt_q == 4'd15;
      end
      S_DATA: begin
        cnt_run  = tick;
        shift_en = tick && tcnt_q == 4'd15;
      end
      S_STOP: begin
        cnt_run  = tick;
        done_ok  = tick && tcnt_q == 4'd9 && vote_stop;
        done_err = tick && tcnt_q == 4'd9 && !vote_stop;
      end
      default: ;
    endcase
  end

  assign samp_en = cnt_run && (tcnt_q >= 4'd7) && (tcnt_q <= 4'd9);

  always_comb begin
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    samp_d  = samp_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ready_d = done_ok;
    ferr_d  = done_err;
    if (tcnt_clr)     tcnt_d = 4'd0;
    else if (cnt_run) tcnt_d = tcnt_q + 4'd1;
    if (bcnt_clr)      bcnt_d = 4'd0;
    else if (shift_en) bcnt_d = bcnt_q + 4'd1;
    if (samp_en) begin
      case (tcnt_q)
        4'd7:    samp_d[0] = rxs;
        4'd8:    samp_d[1] = rxs;
        default: samp_d[2] = rxs;
      endcase
    end
    // Line order is LSB first, so shifting in at the MSB leaves bit 0 at the bottom.
    if (shift_en) shreg_d = {vote_mid, shreg_q[DATA_BITS-1:1]};
    if (done_ok || done_err) data_d = shreg_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      samp_q  <= '1;
      shreg_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      samp_q  <= samp_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_ready  = ready_q;
  assign frame_err = ferr_q;
  assign rx_tickk  = tick_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized bench for uart_rx_core: frames are queued with their expected outcome and
// arrival window, and a monitor checks every strobe and the rx_data hold rule each cycle.
module tb_uart_rx_core;
  localparam int DB = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   baud_divisor = 16'd2;
  logic          rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_ready, frame_err, rx_busy, rx_tickk;

  uart_rx_core #(.DATA_BITS(DB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .baud_divisor(baud_divisor), .rx(rx),
    .rx_data(rx_data), .rx_ready(rx_ready), .frame_err(frame_err),
    .rx_busy(rx_busy), .rx_tickk(rx_tickk)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, errors = 0;
  int n_ready = 0, n_err = 0, tick_cnt = 0;
  logic [DB-1:0] prev_data = '0;

  typedef struct {
    logic [DB-1:0] data;
    logic          ok;
    int            edge_cyc;
    int            div;
  } exp_t;
  exp_t expq[$];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    vectors++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  function automatic int eff_div(input logic [15:0] bd);
    return (bd <= 16'd1) ? 1 : int'(bd);
  endfunction

  // Strobe checker. A frame's stop decision lands 154 ticks after start detect, and detect
  // is SYNC_STAGES cycles plus at most one tick period after the pin falls.
  always @(negedge clk) begin
    if (reset) begin
      if (rx_ready || frame_err) begin
        check("strobe_exclusive", rx_ready & frame_err, 0);
        if (expq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_strobe: got ready=%0b err=%0b data=%0h, expected none", rx_ready, frame_err, rx_data);
        end else begin
          exp_t e;
          int nom;
          e = expq.pop_front();
          nom = (16 * (1 + DB) + 10) * e.div + SS;
          check("strobe_kind", rx_ready, e.ok);
          check("rx_data", rx_data, e.data);
          check_range("latency", cyc - e.edge_cyc, nom, nom + e.div + 2);
        end
        if (rx_ready) n_ready++;
        if (frame_err) n_err++;
      end else begin
        check("rx_data_hold", rx_data, prev_data);
      end
      if (rx_tickk) tick_cnt++;
    end
    prev_data = rx_data;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int d, input bit noisy);
    rx = v;
    for (int i = 0; i < 16 * d; i++) begin
      if (noisy && i == 8 * d + 2) rx = ~v;
      if (noisy && i == 9 * d + 2) rx = v;
      @(posedge clk);
      #1;
    end
  endtask

  // Caller must be aligned to posedge+1.
  task automatic send_frame(input logic [DB-1:0] data, input logic stop, input int noise_bit, input int idle_bits);
    exp_t e;
    int d;
    d = eff_div(baud_divisor);
    e.data = data;
    e.ok = stop;
    e.edge_cyc = cyc;
    e.div = d;
    expq.push_back(e);
    drive_bit(1'b0, d, 1'b0);
    for (int b = 0; b < DB; b++) drive_bit(data[b], d, b == noise_bit);
    drive_bit(stop, d, 1'b0);
    for (int i = 0; i < idle_bits; i++) drive_bit(1'b1, d, 1'b0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000 && rx_busy; i++) step(1);
    check("idle_timeout", rx_busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, e0, t0, d, c0;
    logic [DB-1:0] b;
    logic sb;
    int nb, gap;

    step(3);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_busy", rx_busy, 0);
    check("rst_rx_tickk", rx_tickk, 0);
    reset = 1'b1;
    step(40);

    // Nominal frame at divisor 2 with tick counting over ten bit times.
    r0 = n_ready;
    fork
      send_frame(8'hA5, 1'b1, -1, 2);
      begin
        t0 = tick_cnt;
        step(320);
        check("ticks_per_10_bits", tick_cnt - t0, 160);
      end
    join
    check("nominal_ready_count", n_ready - r0, 1);
    check("nominal_data", rx_data, 8'hA5);
    wait_idle();

    // Reset mid-frame: abort, clear outputs, then receive normally.
    drive_bit(1'b0, 2, 1'b0);
    drive_bit(1'b0, 2, 1'b0);
    drive_bit(1'b1, 2, 1'b0);
    drive_bit(1'b0, 2, 1'b0);
    step(16);
    reset = 1'b0;
    step(1);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_ready", rx_ready, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_rx_busy", rx_busy, 0);
    check("midrst_rx_tickk", rx_tickk, 0);
    step(1);
    reset = 1'b1;
    rx = 1'b1;
    step(2);
    check("postrst_idle", rx_busy, 0);
    step(32 * 12);
    r0 = n_ready;
    send_frame(8'h5A, 1'b1, -1, 2);
    check("postrst_ready_count", n_ready - r0, 1);
    check("postrst_data", rx_data, 8'h5A);

    // Short glitch: start detected, then rejected at the start-bit vote.
    r0 = n_ready;
    e0 = n_err;
    rx = 1'b0;
    step(6);
    rx = 1'b1;
    check("glitch_busy_rises", rx_busy, 1);
    step(40);
    check("glitch_busy_falls", rx_busy, 0);
    check("glitch_no_strobe", (n_ready - r0) + (n_err - e0), 0);
    step(32);

    // One corrupted sample inside bit 4 is outvoted.
    send_frame(8'h3C, 1'b1, 4, 2);
    check("noise_data", rx_data, 8'h3C);

    // Framing error.
    r0 = n_ready;
    e0 = n_err;
    send_frame(8'h81, 1'b0, -1, 2);
    check("ferr_count", n_err - e0, 1);
    check("ferr_no_ready", n_ready - r0, 0);
    check("ferr_data", rx_data, 8'h81);
    wait_idle();

    // Break: 40 bit times low gives one all-zero frame error and a busy receiver.
    e0 = n_err;
    begin
      exp_t e;
      e.data = '0;
      e.ok = 1'b0;
      e.edge_cyc = cyc;
      e.div = 2;
      expq.push_back(e);
    end
    rx = 1'b0;
    step(40 * 32);
    check("break_busy", rx_busy, 1);
    check("break_one_err", n_err - e0, 1);
    rx = 1'b1;
    step(SS + 3);
    check("break_released", rx_busy, 0);
    step(64);

    // Back-to-back frames with a single stop bit.
    r0 = n_ready;
    send_frame(8'h00, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b1, -1, 0);
    send_frame(8'h55, 1'b1, -1, 2);
    check("b2b_ready_count", n_ready - r0, 3);
    check("b2b_last_data", rx_data, 8'h55);

    // Randomized frames, divisors and gaps.
    for (int f = 0; f < 30; f++) begin
      wait_idle();
      if (f % 5 == 0) begin
        baud_divisor = 16'($urandom_range(0, 4));
        step(8);
      end
      b = DB'($urandom);
      sb = ($urandom_range(0, 6) != 0);
      nb = $urandom_range(0, 11);
      gap = sb ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_frame(b, sb, nb, gap);
    end
    step(4 * 16);
    wait_idle();

    c0 = 0;
    d = expq.size();
    for (int i = 0; i < 2000 && expq.size() != 0; i++) begin
      step(1);
      c0++;
    end
    check("pending_expectations", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
